// File: rtl/cobra_exec_ctrl.sv
// cobra_exec_ctrl: run / halt / single-step sequencer for the CYBERcobra core,
// with a PC breakpoint and the IN-port handshake.
// core_en gates the core's pc register and register-file write enable.
// Optional build macro COBRA_EXEC_WATCHDOG_EN adds a WAIT_IN watchdog and the
// sticky wd_trip output; without it WAIT_IN waits indefinitely.
module cobra_exec_ctrl #(
  parameter int unsigned PC_W  = 8,
  parameter int unsigned CNT_W = 32
) (
  input  logic             CLK,
  input  logic             rst,
  input  logic             run_req,
  input  logic             halt_req,
  input  logic             step_req,
  input  logic             bp_en,
  input  logic [PC_W-1:0]  bp_addr,
  input  logic [PC_W-1:0]  pc,
  input  logic [31:0]      instr,
  input  logic [31:0]      in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             core_en,
  output logic [31:0]      core_in,
  output logic [2:0]       state,
  output logic             halted,
  output logic             bp_hit,
`ifdef COBRA_EXEC_WATCHDOG_EN
  output logic             wd_trip,
`endif
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    S_HALT    = 3'd0,
    S_RUN     = 3'd1,
    S_STEP    = 3'd2,
    S_WAIT_IN = 3'd3,
    S_EXEC_IN = 3'd4
  } state_t;

  state_t            state_q, state_d;
  state_t            ret_q, ret_d;
  logic              skip_q, skip_d;
  logic              bp_hit_q, bp_hit_d;
  logic [31:0]       core_in_q, core_in_d;
  logic [CNT_W-1:0]  retired_q;
  logic              commit;
  logic              is_in;
  logic              bp_stop;

  // Only instr[29:28] selects the IN class; the rest of the word is the core's.
  logic              unused_instr_bits;
  assign unused_instr_bits = ^{instr[31:30], instr[27:0]};

  assign is_in   = (instr[29:28] == 2'b01);
  assign bp_stop = bp_en & (pc == bp_addr) & ~skip_q;

`ifdef COBRA_EXEC_WATCHDOG_EN
  logic [15:0] wd_cnt_q, wd_cnt_d;
  logic        wd_trip_q, wd_trip_d;
`endif

  // Next-state, commit enable and handshake decode.
  always_comb begin
    state_d   = state_q;
    ret_d     = ret_q;
    skip_d    = skip_q;
    bp_hit_d  = bp_hit_q;
    core_in_d = core_in_q;
    commit    = 1'b0;
    in_ready  = 1'b0;
`ifdef COBRA_EXEC_WATCHDOG_EN
    wd_cnt_d  = wd_cnt_q;
    wd_trip_d = wd_trip_q;
`endif
    case (state_q)
      S_HALT: begin
        if (run_req) begin
          state_d  = S_RUN;
          skip_d   = 1'b1;
          bp_hit_d = 1'b0;
`ifdef COBRA_EXEC_WATCHDOG_EN
          wd_trip_d = 1'b0;
`endif
        end else if (step_req) begin
          state_d  = S_STEP;
          bp_hit_d = 1'b0;
`ifdef COBRA_EXEC_WATCHDOG_EN
          wd_trip_d = 1'b0;
`endif
        end
      end
      S_RUN: begin
        if (halt_req) begin
          state_d = S_HALT;
        end else if (bp_stop) begin
          bp_hit_d = 1'b1;
          state_d  = S_HALT;
        end else if (is_in) begin
          ret_d   = S_RUN;
          state_d = S_WAIT_IN;
        end else begin
          commit = 1'b1;
          skip_d = 1'b0;
        end
      end
      S_STEP: begin
        if (is_in) begin
          ret_d   = S_HALT;
          state_d = S_WAIT_IN;
        end else begin
          commit  = 1'b1;
          state_d = S_HALT;
        end
      end
      S_WAIT_IN: begin
        in_ready = 1'b1;
        if (halt_req) begin
          state_d = S_HALT;
        end else if (in_valid) begin
          core_in_d = in_data;
          state_d   = S_EXEC_IN;
        end
`ifdef COBRA_EXEC_WATCHDOG_EN
        else if (wd_cnt_q == 16'hFFFF) begin
          wd_trip_d = 1'b1;
          state_d   = S_HALT;
        end else begin
          wd_cnt_d = wd_cnt_q + 16'd1;
        end
`endif
      end
      S_EXEC_IN: begin
        commit  = 1'b1;
        skip_d  = 1'b0;
        state_d = halt_req ? S_HALT : ret_q;
      end
      default: state_d = S_HALT;
    endcase
`ifdef COBRA_EXEC_WATCHDOG_EN
    // Fresh count on every entry into WAIT_IN.
    if ((state_d == S_WAIT_IN) && (state_q != S_WAIT_IN)) begin
      wd_cnt_d = '0;
    end
`endif
  end

  // Controller state, return target and sticky flags.
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      state_q   <= S_HALT;
      ret_q     <= S_HALT;
      skip_q    <= 1'b0;
      bp_hit_q  <= 1'b0;
      core_in_q <= '0;
    end else begin
      state_q   <= state_d;
      ret_q     <= ret_d;
      skip_q    <= skip_d;
      bp_hit_q  <= bp_hit_d;
      core_in_q <= core_in_d;
    end
  end

  // Retired-instruction counter, wraps naturally.
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      retired_q <= '0;
    end else if (commit) begin
      retired_q <= retired_q + CNT_W'(1);
    end
  end

`ifdef COBRA_EXEC_WATCHDOG_EN
  // Watchdog counter and its sticky trip flag.
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      wd_cnt_q  <= '0;
      wd_trip_q <= 1'b0;
    end else begin
      wd_cnt_q  <= wd_cnt_d;
      wd_trip_q <= wd_trip_d;
    end
  end

  assign wd_trip = wd_trip_q;
`endif

  assign core_en = commit;
  assign core_in = core_in_q;
  assign state   = state_q;
  assign halted  = (state_q == S_HALT);
  assign bp_hit  = bp_hit_q;
  assign retired = retired_q;

endmodule

// File: doc/cobra_exec_ctrl.md
Name: cobra_exec_ctrl

Overview:
- Execution controller for the CYBERcobra core: run, halt and single-step sequencing, plus a PC breakpoint.
- The core's state updates only on cycles where `core_en` is high. `core_en` gates the core's pc register and its register-file write enable.
- Performs the IN-port handshake: the core stalls on an IN-type instruction until external data arrives, and that data is then presented on the core's IN port.

Parameters:
- PC_W, 8, width of the core program counter and the breakpoint address.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- CLK  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-low.
- run_req  input  1  pulse: start free-running execution.
- halt_req  input  1  level or pulse: stop execution.
- step_req  input  1  pulse: execute exactly one instruction.
- bp_en  input  1  breakpoint enable.
- bp_addr  input  PC_W  breakpoint PC.
- pc  input  PC_W  current core PC.
- instr  input  32  instruction currently addressed by pc.
- in_data  input  32  external input data.
- in_valid  input  1  in_data valid.
- in_ready  output  1  controller accepts in_data.
- core_en  output  1  core commit enable; combinational from state and inputs.
- core_in  output  32  registered data driven to the core IN port.
- state  output  3  current FSM state encoding.
- halted  output  1  high in HALT.
- bp_hit  output  1  sticky breakpoint-hit flag.
- retired  output  CNT_W  retired-instruction count.

Behaviour:
- Reset (rst low, asynchronous) forces: state=HALT, core_in=0, bp_hit=0, retired=0, skip_bp=0, ret=HALT.
  - Outputs during reset: core_en=0, in_ready=0, halted=1.
- State encodings: HALT=0, RUN=1, STEP=2, WAIT_IN=3, EXEC_IN=4. Encodings 5-7 go to HALT on the next clock.
- is_in = (instr[29:28]==2'b01), independent of instr[31:30].
- bp_stop = bp_en & (pc==bp_addr) & ~skip_bp.
- HALT:
  - core_en=0.
  - run_req: next RUN, skip_bp<=1, bp_hit<=0.
  - else step_req: next STEP, bp_hit<=0.
  - run_req has priority over step_req.
- RUN, priority order:
  - halt_req: core_en=0, next HALT.
  - else bp_stop: core_en=0, bp_hit<=1, next HALT. The instruction at bp_addr is not executed.
  - else is_in: core_en=0, ret<=RUN, next WAIT_IN.
  - else: core_en=1, retired+1, skip_bp<=0, stay RUN.
- STEP (breakpoint ignored, halt_req ignored):
  - is_in: core_en=0, ret<=HALT, next WAIT_IN.
  - else: core_en=1, retired+1, next HALT.
- WAIT_IN:
  - in_ready=1, core_en=0.
  - halt_req: abort, next HALT. No commit, pc unchanged, core_in unchanged.
  - else in_valid: core_in<=in_data, next EXEC_IN. The handshake completes on the clock where in_valid & in_ready.
- EXEC_IN (exactly one cycle):
  - core_en=1, retired+1, skip_bp<=0, next=ret.
  - halt_req in this cycle: the commit still happens, next HALT.
- core_in holds its value until the next handshake.
- retired wraps modulo 2^CNT_W.
- bp_hit clears only on run_req or step_req accepted in HALT, or on reset.
- Latency:
  - RUN: one instruction per cycle.
  - IN-type instruction: at least 3 cycles (RUN->WAIT_IN, handshake, EXEC_IN).
  - run_req: first commit in the cycle after the request.
- halted = (state==HALT).

Optional Feature:
- Macro: COBRA_EXEC_WATCHDOG_EN.
- With the macro:
  - A 16-bit counter counts consecutive WAIT_IN cycles without a handshake.
  - The counter clears on entering WAIT_IN.
  - On reaching 16'hFFFF: next HALT, and sticky output wd_trip (1 bit) is set. wd_trip is cleared like bp_hit.
- Without the macro: no counter, no wd_trip port, WAIT_IN waits indefinitely.

Test Plan:
- Release reset, pulse run_req, instr non-IN (instr[29:28]=2'b11) for 5 cycles -> state=RUN; core_en=1 from the cycle after run_req; retired=5 after 5 commits; halted=0.
- bp_en=1, bp_addr=8'd4, run from pc=0, pc advancing by 1 per commit -> core_en drops when pc==4; bp_hit=1; state=HALT; retired=4. A subsequent run_req commits pc=4 (skip_bp) and continues.
- In HALT, pulse step_req with non-IN instr -> exactly one core_en cycle, retired+1, state returns to HALT.
- RUN hits IN-type instr (instr[29:28]=2'b01); in_valid asserted 3 cycles later with in_data=32'hDEADBEEF -> in_ready=1 throughout WAIT_IN; core_in=32'hDEADBEEF; one-cycle EXEC_IN with core_en=1; then RUN.
- In WAIT_IN, assert halt_req with in_valid=0 -> next state HALT; core_en never high; retired unchanged; core_in unchanged.
- Assert rst low mid-RUN, asynchronously between clock edges -> core_en and in_ready go low immediately; state=HALT; retired=0; bp_hit=0 while rst is held low.
